complex_result_serializer: RTL and testbench

Downstream stage of the complex matrix-by-vector engine. Captures each 512-bit result word (8 complex elements; each element is a 32-bit IEEE-754 single-precision real part in bits [63:32] and a 32-bit imaginary part in bits [31:0]) on the engine's finish pulse. Buffers up to DEPTH words and streams them out one 64-bit complex element per cycle over a valid/ready handshake. Decouples engine completion from the slower result consumer (memory writer or output port).

---
 rtl/complex_result_serializer.sv | 129 ++++++++++++
 tb/tb_complex_result_serializer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/complex_result_serializer.sv
// Buffers 512-bit complex result words and streams them out one 64-bit element per beat.
// Optional NaN flagging on the output element is enabled by defining SERIALIZER_NAN_FLAG_EN.
module complex_result_serializer #(
  parameter int EW    = 64,
  parameter int N     = 8,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [EW*N-1:0]              in_result,
  input  logic                         in_finish,
  output logic                         in_ready,
  output logic [EW-1:0]                out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last,
  output logic [$clog2(N)-1:0]         out_index,
  output logic                         overflow,
  output logic                         out_nan,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t          state, state_next;
  logic [EW*N-1:0] mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr, rd_next;
  logic [IW-1:0]   elem_idx, elem_next;
  logic [CW-1:0]   count_next;
  logic            xfer, pop, wr_en, full;
  logic [EW*N-1:0] next_word;
  logic [EW-1:0]   next_elems [N];
  logic [EW-1:0]   next_elem;

  assign full     = (count == CW'(DEPTH));
  assign in_ready = !full;
  assign xfer     = out_valid && out_ready;

  always_comb begin
    pop       = 1'b0;
    elem_next = elem_idx;
    rd_next   = rd_ptr;
    if (state == IDLE) begin
      elem_next = '0;
    end else if (xfer) begin
      if (elem_idx == IW'(N - 1)) begin
        pop       = 1'b1;
        elem_next = '0;
        rd_next   = rd_ptr + PW'(1);
      end else begin
        elem_next = elem_idx + IW'(1);
      end
    end
  end

  // A slot freed by the last-element pop can be refilled on the same edge.
  assign wr_en      = in_finish && (!full || pop);
  assign count_next = count + CW'(wr_en) - CW'(pop);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (count != '0) state_next = STREAM;
      STREAM:  if (pop && count_next == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bypass covers the word being written into the slot we are about to read.
  assign next_word = (wr_en && wr_ptr == rd_next) ? in_result : mem[rd_next];

  for (genvar g = 0; g < N; g++) begin : g_split
    assign next_elems[g] = next_word[(N-1-g)*EW +: EW];
  end

  assign next_elem = next_elems[elem_next];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= in_result;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      elem_idx  <= '0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
    end else begin
      state    <= state_next;
      rd_ptr   <= rd_next;
      elem_idx <= elem_next;
      count    <= count_next;
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (in_finish && !wr_en) overflow <= 1'b1;
      out_valid <= (state_next == STREAM);
      out_data  <= (state_next == STREAM) ? next_elem : '0;
      out_index <= (state_next == STREAM) ? elem_next : '0;
      out_last  <= (state_next == STREAM) && (elem_next == IW'(N - 1));
    end
  end

`ifdef SERIALIZER_NAN_FLAG_EN
  function automatic logic is_nan(input logic [31:0] f);
    return (&f[30:23]) && (|f[22:0]);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_nan <= 1'b0;
    end else begin
      out_nan <= (state_next == STREAM) &&
                 (is_nan(next_elem[EW-1 -: 32]) || is_nan(next_elem[31:0]));
    end
  end
`else
  assign out_nan = 1'b0;
`endif

endmodule

// File: tb/tb_complex_result_serializer.sv
// Directed self-checking bench for complex_result_serializer.
module tb_complex_result_serializer;

  localparam int EW    = 64;
  localparam int N     = 8;
  localparam int DEPTH = 2;
`ifdef SERIALIZER_NAN_FLAG_EN
  localparam bit NAN_EN = 1'b1;
`else
  localparam bit NAN_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [EW*N-1:0] in_result = '0;
  logic            in_finish = 1'b0;
  logic            in_ready;
  logic [EW-1:0]   out_data;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic            out_last;
  logic [2:0]      out_index;
  logic            overflow;
  logic            out_nan;
  logic [1:0]      count;

  int checks   = 0;
  int failures = 0;

  complex_result_serializer #(.EW(EW), .N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_result(in_result), .in_finish(in_finish),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .out_index(out_index),
    .overflow(overflow), .out_nan(out_nan), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [EW*N-1:0] build_word(input logic [31:0] re_base,
                                                 input logic [31:0] im);
    logic [EW*N-1:0] w;
    w = '0;
    for (int k = 0; k < N; k++) begin
      w = {w[EW*(N-1)-1:0], re_base + 32'(k), im};
    end
    return w;
  endfunction

  function automatic logic [EW-1:0] elem_of(input logic [EW*N-1:0] w, input int k);
    return EW'(w >> ((N - 1 - k) * EW));
  endfunction

  // Pulses in_finish for one cycle; returns at the negedge after the write edge.
  task automatic apply_stimulus(input logic [EW*N-1:0] word);
    in_result = word;
    in_finish = 1'b1;
    @(negedge clk);
    in_finish = 1'b0;
  endtask

  // Expects beat 0 visible now and out_ready held high for N beats.
  task automatic stream_word(input logic [EW*N-1:0] word, input logic [N-1:0] nan_mask,
                             input string tag);
    for (int k = 0; k < N; k++) begin
      check_output({tag, "_valid"}, 64'(out_valid), 64'd1);
      check_output({tag, "_index"}, 64'(out_index), 64'(k));
      check_output({tag, "_last"}, 64'(out_last), (k == N - 1) ? 64'd1 : 64'd0);
      check_output({tag, "_data"}, out_data, elem_of(word, k));
      check_output({tag, "_nan"}, 64'(out_nan), 64'(NAN_EN && nan_mask[k[2:0]]));
      @(negedge clk);
    end
  endtask

  logic [EW*N-1:0] word_a, word_b, word_c, word_d, word_e, word_f, word_g, word_h;
  logic [EW*N-1:0] word_i, word_j, word_k;
  int beat, guard;
  logic rdy;

  initial begin
    word_a = {N{64'h3f800000_00000000}};
    word_b = build_word(32'h3f800000, 32'h0);
    word_c = build_word(32'hc0000000, 32'h11111111);
    word_d = build_word(32'h40490fd0, 32'h22222222);
    word_e = build_word(32'hbf800000, 32'h33333333);
    word_f = build_word(32'h41200000, 32'h44440000);
    word_g = build_word(32'h42c80000, 32'h55550000);
    word_h = build_word(32'h3e800000, 32'h66660000);
    word_i = build_word(32'h3fc00000, 32'h77770000);
    word_j = build_word(32'h40000000, 32'h0000abcd);
    word_k = build_word(32'h3f000000, 32'h0);
    word_k[(N-1-2)*EW +: EW] = 64'h7fc00000_00000000;
    word_k[(N-1-5)*EW +: EW] = 64'h7f800000_00000000;
    word_k[(N-1-6)*EW +: EW] = 64'h00000000_7f800001;

    $display("[TB] reset state");
    repeat (2) @(negedge clk);
    check_output("rst_valid", 64'(out_valid), 64'd0);
    check_output("rst_last", 64'(out_last), 64'd0);
    check_output("rst_index", 64'(out_index), 64'd0);
    check_output("rst_data", out_data, 64'd0);
    check_output("rst_overflow", 64'(overflow), 64'd0);
    check_output("rst_nan", 64'(out_nan), 64'd0);
    check_output("rst_in_ready", 64'(in_ready), 64'd1);
    check_output("rst_count", 64'(count), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] single word, out_ready high");
    out_ready = 1'b1;
    apply_stimulus(word_a);
    check_output("a_count_after_write", 64'(count), 64'd1);
    check_output("a_valid_latency", 64'(out_valid), 64'd0);
    @(negedge clk);
    stream_word(word_a, '0, "a");
    check_output("a_idle_valid", 64'(out_valid), 64'd0);
    check_output("a_idle_count", 64'(count), 64'd0);

    $display("[TB] toggling out_ready");
    apply_stimulus(word_b);
    beat  = 0;
    guard = 0;
    rdy   = 1'b1;
    while (beat < N && guard < 40) begin
      @(negedge clk);
      guard++;
      if (out_valid) begin
        check_output("b_index", 64'(out_index), 64'(beat));
        check_output("b_data", out_data, elem_of(word_b, beat));
        check_output("b_last", 64'(out_last), (beat == N - 1) ? 64'd1 : 64'd0);
        out_ready = rdy;
        if (rdy) beat++;
        rdy = !rdy;
      end
    end
    check_output("b_beats_done", 64'(beat), 64'(N));
    @(negedge clk);
    check_output("b_idle_valid", 64'(out_valid), 64'd0);
    check_output("b_idle_count", 64'(count), 64'd0);

    $display("[TB] overflow on third back-to-back word");
    out_ready = 1'b0;
    in_finish = 1'b1;
    in_result = word_c;
    @(negedge clk);
    in_result = word_d;
    @(negedge clk);
    in_result = word_e;
    @(negedge clk);
    in_finish = 1'b0;
    check_output("ov_count", 64'(count), 64'd2);
    check_output("ov_in_ready", 64'(in_ready), 64'd0);
    check_output("ov_flag", 64'(overflow), 64'd1);
    @(negedge clk);
    check_output("ov_flag_sticky", 64'(overflow), 64'd1);
    out_ready = 1'b1;
    stream_word(word_c, '0, "ov_c");
    stream_word(word_d, '0, "ov_d");
    check_output("ov_idle_valid", 64'(out_valid), 64'd0);
    check_output("ov_idle_count", 64'(count), 64'd0);
    check_output("ov_flag_after", 64'(overflow), 64'd1);

    reset = 1'b0;
    @(negedge clk);
    check_output("ov_cleared_by_reset", 64'(overflow), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] write coincident with last-element pop on full buffer");
    out_ready = 1'b0;
    in_finish = 1'b1;
    in_result = word_f;
    @(negedge clk);
    in_result = word_g;
    @(negedge clk);
    in_finish = 1'b0;
    check_output("co_count_full", 64'(count), 64'd2);
    out_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      check_output("co_f_index", 64'(out_index), 64'(k));
      check_output("co_f_data", out_data, elem_of(word_f, k));
      if (k == N - 1) begin
        check_output("co_in_ready_full", 64'(in_ready), 64'd0);
        in_finish = 1'b1;
        in_result = word_h;
      end
      @(negedge clk);
      in_finish = 1'b0;
    end
    check_output("co_count_kept", 64'(count), 64'd2);
    check_output("co_no_overflow", 64'(overflow), 64'd0);
    stream_word(word_g, '0, "co_g");
    stream_word(word_h, '0, "co_h");
    check_output("co_idle_valid", 64'(out_valid), 64'd0);
    check_output("co_idle_count", 64'(count), 64'd0);

    $display("[TB] reset mid-stream");
    apply_stimulus(word_i);
    @(negedge clk);
    for (int k = 0; k < 3; k++) @(negedge clk);
    check_output("mr_index_before", 64'(out_index), 64'd3);
    reset = 1'b0;
    #1;
    check_output("mr_valid", 64'(out_valid), 64'd0);
    check_output("mr_data", out_data, 64'd0);
    check_output("mr_index", 64'(out_index), 64'd0);
    check_output("mr_last", 64'(out_last), 64'd0);
    check_output("mr_count", 64'(count), 64'd0);
    check_output("mr_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_output("mr_stays_idle", 64'(out_valid), 64'd0);
    apply_stimulus(word_j);
    @(negedge clk);
    stream_word(word_j, '0, "mr_j");
    check_output("mr_idle_valid", 64'(out_valid), 64'd0);

    $display("[TB] NaN flagging");
    apply_stimulus(word_k);
    @(negedge clk);
    stream_word(word_k, 8'b0100_0100, "nan");
    check_output("nan_idle", 64'(out_nan), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
